ps2_rx_scancode: RTL and testbench



---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_clk_filter.sv | 42 ++++
 rtl/ps2_rx_scancode.sv | 121 ++++++++++++
 tb/tb_ps2_rx_scancode.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DPS  = 2'b01,
        LOAD = 2'b10
    } state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam int         FRAME_BITS = 11;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 lines, debounces the PS/2 clock and flags its falling edges.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall_edge,
    output logic ps2d_sync
);

    logic [1:0]            c_sync_q;
    logic [1:0]            d_sync_q;
    logic [FILTER_LEN-1:0] filt_reg;
    logic                  filt_c;
    logic                  filt_c_prev;

    // The filtered clock only moves once FILTER_LEN consecutive samples agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_q    <= 2'b11;
            d_sync_q    <= 2'b11;
            filt_reg    <= '1;
            filt_c      <= 1'b1;
            filt_c_prev <= 1'b1;
        end else begin
            c_sync_q    <= {c_sync_q[0], ps2c};
            d_sync_q    <= {d_sync_q[0], ps2d};
            filt_reg    <= {c_sync_q[1], filt_reg[FILTER_LEN-1:1]};
            filt_c_prev <= filt_c;
            if (&filt_reg)
                filt_c <= 1'b1;
            else if (~|filt_reg)
                filt_c <= 1'b0;
        end
    end

    assign fall_edge = filt_c_prev & ~filt_c;
    assign ps2d_sync = d_sync_q[1];

endmodule

// File: rtl/ps2_rx_scancode.sv
// PS/2 keyboard receiver: frames bytes, checks parity/stop, and reports only make codes.
module ps2_rx_scancode
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYC    = 100000,
    parameter int SUPPRESS_BREAK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] data_out,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic                  fall_edge;
    logic                  ps2d_sync;
    state_t                state;
    logic [3:0]            n;
    logic [FRAME_BITS-1:0] b;
    logic [TW-1:0]         timeout_cnt;
    logic                  break_pending;
    logic                  ext_pending;
    logic [7:0]            rx_byte;
    logic                  frame_ok;
    logic                  parity_ok;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2c     (ps2c),
        .ps2d     (ps2d),
        .fall_edge(fall_edge),
        .ps2d_sync(ps2d_sync)
    );

    // b[0] is never shifted into, so it still holds the cleared start position.
    assign rx_byte   = b[8:1];
    assign frame_ok  = b[10] & ~b[0];
    assign parity_ok = ^b[9:1];

    // Start bit is consumed in IDLE; DPS shifts in 8 data bits, parity and stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            n             <= 4'd0;
            b             <= '0;
            timeout_cnt   <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            data_out      <= 8'h00;
            rx_done_tick  <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_edge && rx_en && !ps2d_sync) begin
                        state       <= DPS;
                        n           <= 4'(FRAME_BITS - 2);
                        b           <= '0;
                        timeout_cnt <= '0;
                    end
                end
                DPS: begin
                    if (fall_edge) begin
                        b           <= {ps2d_sync, b[FRAME_BITS-1:1]};
                        timeout_cnt <= '0;
                        if (n == 4'd0)
                            state <= LOAD;
                        else
                            n <= n - 4'd1;
                    end else if (timeout_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                    end else if (!parity_ok) begin
                        parity_err <= 1'b1;
                    end else if (SUPPRESS_BREAK != 0) begin
                        if (rx_byte == EXT_CODE) begin
                            ext_pending <= 1'b1;
                        end else if (rx_byte == BREAK_CODE) begin
                            break_pending <= 1'b1;
                        end else if (break_pending) begin
                            break_pending <= 1'b0;
                            ext_pending   <= 1'b0;
                        end else begin
                            data_out     <= rx_byte;
                            rx_done_tick <= 1'b1;
                            if (ext_pending)
                                ext_pending <= 1'b0;
                        end
                    end else begin
                        data_out     <= rx_byte;
                        rx_done_tick <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_scancode.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and compares them.
module tb_ps2_rx_scancode;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 40;

    localparam logic [1:0] EV_DATA = 2'd0;
    localparam logic [1:0] EV_PAR  = 2'd1;
    localparam logic [1:0] EV_FRM  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } event_t;

    logic       clk;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic [7:0] data_out;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    event_t     exp_q[$];
    int         errors;
    int         checks;
    logic [7:0] exp_data;

    ps2_rx_scancode #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYC   (TIMEOUT_CYC),
        .SUPPRESS_BREAK(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .rx_en       (rx_en),
        .data_out    (data_out),
        .rx_done_tick(rx_done_tick),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clks(input int cycles);
        repeat (cycles) @(posedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic push_expect(input logic [1:0] kind, input logic [7:0] data);
        event_t ev;
        ev.kind = kind;
        ev.data = data;
        exp_q.push_back(ev);
        if (kind == EV_DATA)
            exp_data = data;
    endtask

    // Sends nbits of an 11-bit frame, optionally with single-cycle glitches on ps2c.
    task automatic apply_stimulus(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                                  input int nbits, input bit glitch);
        logic [10:0] f;
        f = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            if (glitch) begin
                wait_clks(HALF / 2);
                ps2c = 1'b0;
                wait_clks(1);
                ps2c = 1'b1;
                wait_clks(HALF / 2 - 1);
            end else begin
                wait_clks(HALF);
            end
            ps2c = 1'b0;
            if (glitch) begin
                wait_clks(HALF / 2);
                ps2c = 1'b1;
                wait_clks(1);
                ps2c = 1'b0;
                wait_clks(HALF / 2 - 1);
            end else begin
                wait_clks(HALF);
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        wait_clks(4 * HALF);
    endtask

    task automatic compare_event(input logic [1:0] kind, input logic [7:0] data);
        event_t ev;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got kind=%0d data=%0h, expected no event", kind, data);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind !== kind || ev.data !== data) begin
                errors++;
                $display("[TB] FAIL event: got kind=%0d data=%0h, expected kind=%0d data=%0h",
                         kind, data, ev.kind, ev.data);
            end
        end
    endtask

    // Monitor samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_done_tick && (parity_err || frame_err))
                check_output("tick_err_overlap", 32'd1, 32'd0);
            if (rx_done_tick)
                compare_event(EV_DATA, data_out);
            if (parity_err)
                compare_event(EV_PAR, 8'h00);
            if (frame_err)
                compare_event(EV_FRM, 8'h00);
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors   = 0;
        checks   = 0;
        exp_data = 8'h00;
        reset    = 1'b1;
        ps2c     = 1'b1;
        ps2d     = 1'b1;
        rx_en    = 1'b1;
        wait_clks(5);
        @(negedge clk);
        check_output("reset_data_out", {24'd0, data_out}, 32'h00);
        check_output("reset_tick", {31'd0, rx_done_tick}, 32'd0);
        check_output("reset_perr", {31'd0, parity_err}, 32'd0);
        check_output("reset_ferr", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        wait_clks(20);

        push_expect(EV_DATA, 8'h5A);
        apply_stimulus(8'h5A, 0, 0, 11, 0);
        check_output("data_5a", {24'd0, data_out}, {24'd0, exp_data});

        push_expect(EV_DATA, 8'h16);
        apply_stimulus(8'h16, 0, 0, 11, 0);
        apply_stimulus(8'hF0, 0, 0, 11, 0);
        apply_stimulus(8'h16, 0, 0, 11, 0);
        check_output("break_seq", {24'd0, data_out}, {24'd0, exp_data});

        push_expect(EV_PAR, 8'h00);
        apply_stimulus(8'h1E, 1, 0, 11, 0);
        check_output("parity_hold", {24'd0, data_out}, 32'h16);

        push_expect(EV_FRM, 8'h00);
        apply_stimulus(8'h26, 0, 1, 11, 0);
        check_output("stop_hold", {24'd0, data_out}, 32'h16);
        push_expect(EV_DATA, 8'h24);
        apply_stimulus(8'h24, 0, 0, 11, 0);
        check_output("data_24", {24'd0, data_out}, 32'h24);

        push_expect(EV_FRM, 8'h00);
        apply_stimulus(8'h55, 0, 0, 5, 0);
        wait_clks(TIMEOUT_CYC + 200);
        check_output("timeout_drained", exp_q.size(), 32'd0);
        push_expect(EV_DATA, 8'h33);
        apply_stimulus(8'h33, 0, 0, 11, 0);
        check_output("data_33", {24'd0, data_out}, 32'h33);

        push_expect(EV_DATA, 8'h75);
        apply_stimulus(8'hE0, 0, 0, 11, 0);
        apply_stimulus(8'h75, 0, 0, 11, 0);
        apply_stimulus(8'hE0, 0, 0, 11, 0);
        apply_stimulus(8'hF0, 0, 0, 11, 0);
        apply_stimulus(8'h75, 0, 0, 11, 0);
        check_output("ext_seq", {24'd0, data_out}, 32'h75);

        rx_en = 1'b0;
        apply_stimulus(8'h44, 0, 0, 11, 0);
        rx_en = 1'b1;
        check_output("rx_en_gate", {24'd0, data_out}, 32'h75);

        push_expect(EV_DATA, 8'h29);
        push_expect(EV_DATA, 8'h29);
        apply_stimulus(8'h29, 0, 0, 11, 0);
        apply_stimulus(8'h29, 0, 0, 11, 0);
        check_output("typematic", {24'd0, data_out}, 32'h29);

        push_expect(EV_DATA, 8'h31);
        apply_stimulus(8'h31, 0, 0, 11, 1);
        check_output("glitch_31", {24'd0, data_out}, 32'h31);

        apply_stimulus(8'h31, 0, 0, 5, 0);
        reset = 1'b1;
        exp_data = 8'h00;
        wait_clks(3);
        @(negedge clk);
        check_output("midframe_reset", {24'd0, data_out}, {24'd0, exp_data});
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        reset = 1'b0;
        wait_clks(500);
        check_output("post_reset_data", {24'd0, data_out}, 32'h00);

        for (int i = 0; i < 5000 && exp_q.size() != 0; i++)
            wait_clks(1);
        check_output("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
